// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder.
// Contents:
//   state_t         - responder FSM state encoding
//   TOGGLE_ADDR_DEF - default byte address of the toggle register
//   CNT_W           - wait-state counter width
package mem_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] TOGGLE_ADDR_DEF = 32'h0000_1000;
  localparam int          CNT_W           = 4;
endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with registered read data.
// Ports:
//   clk   - rising-edge clock
//   we    - write enable: mem[idx] <= wdata
//   re    - read enable: rdata <= mem[idx]; rdata holds while re=0
//   idx   - word index
//   wdata - write data
//   rdata - registered read data
// Contents are never cleared.
module mem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata <= mem[idx];
  end
endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the CPU load/store/fetch port.
// Accepts one request at a time, waits LATENCY cycles, then returns a
// one-cycle response from the word RAM or the memory-mapped toggle register.
// Ports:
//   clk          - rising-edge clock
//   resetn       - synchronous reset, ACTIVE HIGH despite the name
//   req_valid    - request present
//   req_ready    - responder idle, request accepted this cycle if valid
//   req_we       - 1 = write, 0 = read
//   req_addr     - byte address
//   req_wdata    - write data
//   rsp_valid    - one-cycle completion pulse
//   rsp_rdata    - read data (held until the next response)
//   rsp_err      - misaligned or unmapped access (held until the next response)
//   toggle_value - toggle register contents
module mem_responder
  import mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] TOGGLE_ADDR = TOGGLE_ADDR_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] toggle_value
);
  localparam int             AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0]    RAM_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("mem_responder: LATENCY must be in 1..15");
    end
  endgenerate

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              enter_resp;

  logic              cap_we;
  logic [31:0]       cap_addr, cap_wdata;
  logic              cur_we;
  logic [31:0]       cur_addr, cur_wdata;

  logic              misal, ram_hit, tog_hit;
  logic              ram_we, ram_re;
  logic [31:0]       ram_rdata;
  logic [31:0]       rdata_q;
  logic              rd_from_ram;

  // With LATENCY=1 the RESP-entry edge is the acceptance edge itself, so
  // decode must look at the live inputs while still in IDLE.
  assign cur_we    = (state == IDLE) ? req_we    : cap_we;
  assign cur_addr  = (state == IDLE) ? req_addr  : cap_addr;
  assign cur_wdata = (state == IDLE) ? req_wdata : cap_wdata;

  assign misal   = (cur_addr[1:0] != 2'b00);
  assign ram_hit = !misal && (cur_addr < RAM_BYTES);
  assign tog_hit = !misal && (cur_addr == TOGGLE_ADDR);

  // Reset on the RESP-entry edge discards the pending write.
  assign ram_we = enter_resp && ram_hit &&  cur_we && !resetn;
  assign ram_re = enter_resp && ram_hit && !cur_we && !resetn;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state        <= IDLE;
      cnt          <= '0;
      cap_we       <= 1'b0;
      cap_addr     <= '0;
      cap_wdata    <= '0;
      toggle_value <= '0;
      rdata_q      <= '0;
      rsp_err      <= 1'b0;
      rd_from_ram  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && req_valid) begin
        cap_we    <= req_we;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
      end
      if (enter_resp) begin
        rd_from_ram <= ram_hit && !cur_we;
        rsp_err     <= !(ram_hit || tog_hit);
        rdata_q     <= (tog_hit && !cur_we) ? toggle_value : 32'h0;
        if (tog_hit && cur_we) toggle_value <= cur_wdata;
      end
    end
  end

  mem_array #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .idx   (cur_addr[AW+1:2]),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

  // RAM read data lives in the array's output register, which only updates
  // on RAM reads, so it holds alongside rdata_q until the next response.
  assign rsp_rdata = rd_from_ram ? ram_rdata : rdata_q;
  assign rsp_valid = (state == RESP);
  assign req_ready = (state == IDLE);
endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: three instances (LATENCY 2, 1, 15) sharing
// one clock and reset, each checked against a reference memory/toggle model.
module tb_mem_responder;
  localparam int N = 3;

  function automatic int lat_of(int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 15);
  endfunction

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid [N];
  logic        req_we    [N];
  logic [31:0] req_addr  [N];
  logic [31:0] req_wdata [N];
  logic        req_ready [N];
  logic        rsp_valid [N];
  logic [31:0] rsp_rdata [N];
  logic        rsp_err   [N];
  logic [31:0] toggle_value [N];

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] ref_mem   [N][1024];
  bit          ref_known [N][1024];
  logic [31:0] ref_tog   [N];

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < N; g++) begin : g_dut
      mem_responder #(
        .DEPTH_WORDS (1024),
        .LATENCY     (lat_of(g)),
        .TOGGLE_ADDR (32'h0000_1000)
      ) u_dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid[g]),
        .req_ready    (req_ready[g]),
        .req_we       (req_we[g]),
        .req_addr     (req_addr[g]),
        .req_wdata    (req_wdata[g]),
        .rsp_valid    (rsp_valid[g]),
        .rsp_rdata    (rsp_rdata[g]),
        .rsp_err      (rsp_err[g]),
        .toggle_value (toggle_value[g])
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction on instance d, checked against the model.
  task automatic transact(input int d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata);
    int          k;
    int          widx;
    bit          seen;
    bit          exp_err;
    bit          chk_rd;
    logic [31:0] exp_rd;
    exp_err = 1'b0;
    chk_rd  = 1'b0;
    exp_rd  = 32'h0;
    widx    = int'(addr[11:2]);
    if (addr[1:0] != 2'b00) begin
      exp_err = 1'b1; chk_rd = 1'b1;
    end else if (addr < 32'd4096) begin
      if (we) begin
        chk_rd = 1'b1;
        ref_mem[d][widx]   = wdata;
        ref_known[d][widx] = 1'b1;
      end else if (ref_known[d][widx]) begin
        chk_rd = 1'b1;
        exp_rd = ref_mem[d][widx];
      end
    end else if (addr == 32'h0000_1000) begin
      if (we) ref_tog[d] = wdata;
      else begin chk_rd = 1'b1; exp_rd = ref_tog[d]; end
    end else begin
      exp_err = 1'b1; chk_rd = 1'b1;
    end

    @(negedge clk);
    chk("ready_idle", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    @(posedge clk);
    #1;
    // Inputs are don't-care after acceptance; scramble them.
    req_valid[d] = 1'b0;
    req_we[d]    = 1'($urandom);
    req_addr[d]  = $urandom;
    req_wdata[d] = $urandom;

    k = 0; seen = 1'b0;
    while (k < lat_of(d) + 5 && !seen) begin
      @(negedge clk);
      k++;
      if (k == 1) chk("ready_busy", 32'(req_ready[d]), 32'd0);
      if (rsp_valid[d]) seen = 1'b1;
    end
    chk("rsp_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("latency", 32'(k), 32'(lat_of(d)));
      chk("rsp_err", 32'(rsp_err[d]), 32'(exp_err));
      if (chk_rd) chk("rsp_rdata", rsp_rdata[d], exp_rd);
      chk("toggle", toggle_value[d], ref_tog[d]);
    end
    @(negedge clk);
    chk("rsp_pulse", 32'(rsp_valid[d]), 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] w;
    w = 32'($urandom_range(0, 31)) << 2;
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: return w;
      6:       return 32'h0000_1000;
      7:       return w + 32'($urandom_range(1, 3));
      8:       return 32'h0000_4000 + w;
      default: return 32'h0000_0FFC;
    endcase
  endfunction

  initial begin
    logic [31:0] a;
    for (int d = 0; d < N; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0;
      req_addr[d] = '0; req_wdata[d] = '0;
      ref_tog[d] = '0;
      for (int i = 0; i < 1024; i++) ref_known[d][i] = 1'b0;
    end

    // Reset state
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < N; d++) begin
      chk("rst_valid", 32'(rsp_valid[d]), 32'd0);
      chk("rst_err", 32'(rsp_err[d]), 32'd0);
      chk("rst_rdata", rsp_rdata[d], 32'd0);
      chk("rst_toggle", toggle_value[d], 32'd0);
    end
    resetn = 1'b0;
    @(negedge clk);
    for (int d = 0; d < N; d++) chk("rst_ready", 32'(req_ready[d]), 32'd1);

    // Directed, LATENCY=2
    transact(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    transact(0, 1'b0, 32'h10, 32'h0);
    transact(0, 1'b1, 32'h1000, 32'h0000_00A5);
    transact(0, 1'b0, 32'h1000, 32'h0);
    transact(0, 1'b0, 32'h12, 32'h0);
    transact(0, 1'b1, 32'h4000, 32'h5555_AAAA);
    transact(0, 1'b0, 32'h10, 32'h0);
    transact(0, 1'b1, 32'hFFC, 32'h0BAD_F00D);
    transact(0, 1'b0, 32'hFFC, 32'h0);
    transact(0, 1'b0, 32'h1004, 32'h0);

    // Random, LATENCY=2
    for (int i = 0; i < 40; i++) begin
      a = rand_addr();
      transact(0, 1'($urandom), a, $urandom);
    end

    // Reset while WAIT; the next edge is also the RESP-entry edge
    transact(0, 1'b1, 32'h20, 32'hCAFE_0001);
    transact(0, 1'b1, 32'h1000, 32'h0000_0055);
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1;
    req_addr[0] = 32'h20; req_wdata[0] = 32'h0000_1234;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    chk("mid_wait_ready", 32'(req_ready[0]), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    resetn = 1'b0;
    for (int d = 0; d < N; d++) ref_tog[d] = '0;
    chk("mid_rst_toggle", toggle_value[0], 32'd0);
    chk("mid_rst_ready", 32'(req_ready[0]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("mid_rst_novalid", 32'(rsp_valid[0]), 32'd0);
      @(negedge clk);
    end
    transact(0, 1'b0, 32'h20, 32'h0);

    // LATENCY=1: continuous req_valid, strict alternation
    transact(1, 1'b1, 32'h1000, 32'h0000_0077);
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0;
    req_addr[1] = 32'h1000; req_wdata[1] = '0;
    for (int k = 0; k < 20; k++) begin
      chk("hold_valid", 32'(rsp_valid[1]), 32'(k % 2));
      chk("hold_ready", 32'(req_ready[1]), 32'((k + 1) % 2));
      if (rsp_valid[1]) chk("hold_rdata", rsp_rdata[1], 32'h0000_0077);
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      a = rand_addr();
      transact(1, 1'($urandom), a, $urandom);
    end

    // LATENCY=15
    transact(2, 1'b1, 32'h40, 32'h1357_9BDF);
    transact(2, 1'b0, 32'h40, 32'h0);
    for (int i = 0; i < 6; i++) begin
      a = rand_addr();
      transact(2, 1'($urandom), a, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multi-cycle CPU's load/store/fetch port.
- Accepts one request at a time (address, write enable, write data) through a valid/ready handshake.
- Services it from a word-addressed on-chip RAM or a memory-mapped toggle register after a fixed, parameterised wait-state latency, and returns a one-cycle response.
- Sits between the CPU datapath's address mux/WriteData path and storage; it is the responder for the datapath's initiator-side memory interface.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit RAM words; RAM occupies byte addresses 0 .. DEPTH_WORDS*4-1.
- LATENCY, 2, cycles from request acceptance edge to the rsp_valid cycle; legal range 1..15, elaboration error otherwise.
- TOGGLE_ADDR, 32'h0000_1000, byte address of the toggle register; must lie outside the RAM range.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  synchronous reset, active-high despite the port name; sampled on the rising edge of clk.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle pulse: response/completion.
- rsp_rdata  out  32  read data, valid when rsp_valid=1.
- rsp_err  out  1  access error flag, valid when rsp_valid=1.
- toggle_value  out  32  current toggle register contents.

Behaviour:
- Reset (resetn=1 at a clock edge):
  - state := IDLE; rsp_valid := 0; rsp_rdata := 0; rsp_err := 0; toggle_value := 0; wait counter := 0.
  - req_ready is 1 in the first cycle after reset.
  - RAM contents are not cleared.
- States:
  - IDLE: req_ready=1.
  - WAIT: req_ready=0.
  - RESP: req_ready=0, rsp_valid=1.
- Acceptance:
  - A request is accepted on an edge where state=IDLE and req_valid=1.
  - At that edge, req_we/req_addr/req_wdata are captured into internal registers. Inputs are don't-care afterwards.
- Transitions:
  - IDLE->RESP if LATENCY=1. Otherwise IDLE->WAIT with counter := LATENCY-2.
  - WAIT decrements the counter; WAIT->RESP when the counter is 0.
  - RESP->IDLE unconditionally.
  - Consequence: rsp_valid is high exactly LATENCY cycles after the acceptance edge, for exactly one cycle.
  - Back-to-back throughput is one request per LATENCY+1 cycles.
- Decode (on the captured address, at the edge entering RESP):
  - Misaligned (addr[1:0] != 0): rsp_err=1, rsp_rdata=0, no state change. Takes priority over the other cases.
  - RAM hit (addr < DEPTH_WORDS*4): word index addr[31:2].
    - Write: RAM[idx] := wdata; rsp_rdata=0.
    - Read: rsp_rdata := RAM[idx].
  - Toggle hit (addr == TOGGLE_ADDR):
    - Write: toggle_value := wdata, visible the same cycle rsp_valid rises.
    - Read: rsp_rdata := toggle_value.
  - Any other address: rsp_err=1, rsp_rdata=0, no write.
- rsp_rdata and rsp_err hold their values until the next RESP. Only rsp_valid qualifies them.
- req_valid is ignored outside IDLE; no queuing, no back-pressure beyond req_ready=0.
- Reset mid-operation (WAIT or RESP): the pending request is discarded and its write is not performed, even if reset coincides with the RESP-entry edge.
- A read issued after a write to the same address returns the new data; writes complete before rsp_valid.

Decomposition:
- Shared package mem_pkg:
  - state encoding IDLE=2'd0, WAIT=2'd1, RESP=2'd2;
  - default TOGGLE_ADDR;
  - latency counter width (4 bits).
- One sub-module, mem_array: a single-port synchronous RAM with write enable, word index, wdata and registered rdata. It is instantiated by mem_responder.
- The FSM, decode and toggle register stay in the top module.

Test Plan:
- Reset, LATENCY=2: write 0xDEADBEEF to 0x10 -> req_ready drops the next cycle, rsp_valid exactly 2 cycles after acceptance with rsp_err=0. Read 0x10 -> rsp_rdata=0xDEADBEEF.
- Write 0x0000_00A5 to 0x1000, then read 0x1000 -> toggle_value=0xA5 in the rsp_valid cycle of the write; read returns 0xA5.
- Read 0x12 (misaligned) and write 0x4000 (unmapped, DEPTH_WORDS=1024) -> rsp_err=1, rsp_rdata=0; a subsequent read of 0x10 is unchanged.
- Hold req_valid=1 continuously with LATENCY=1 -> acceptances every 2 cycles; rsp_valid never high two consecutive cycles.
- Assert resetn for one cycle while in WAIT during a write of 0x1234 to 0x20 -> no rsp_valid; a later read of 0x20 returns the prior value; toggle_value=0.
- Sweep LATENCY=1 and 15 -> rsp_valid exactly 1 and 15 cycles after acceptance respectively.
